// File: rtl/dcache_write_buffer_if.sv
// Cache-side and memory-side handshake bundle for the D-cache write buffer.
// slave = the buffer itself, master = the cache plus slow-memory environment.
interface dcache_write_buffer_if #(
  parameter int AW = 28,
  parameter int DW = 128
);
  logic          cache_read;
  logic          cache_write;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic [DW-1:0] cache_rdata;
  logic          cache_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  cache_read, cache_write, cache_addr, cache_wdata, mem_rdata, mem_ready,
    output cache_rdata, cache_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cache_read, cache_write, cache_addr, cache_wdata, mem_rdata, mem_ready,
    input  cache_rdata, cache_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_write_buffer.sv
// Coalescing line write-back buffer between the D-cache and slow memory.
// Serves read hits from buffered lines; read misses bypass pending writes.
module dcache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 28,
  parameter int DW    = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  dcache_write_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t                   state_q, state_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     done_q, done_d;
  logic                     mem_read_q, mem_read_d;
  logic                     mem_write_q, mem_write_d;
  logic [AW-1:0]            mem_addr_q, mem_addr_d;
  logic [DW-1:0]            mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]            rdata_q, rdata_d;

  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          pop, full, can_acc, head_hit;
  logic          wr_req, wr_hit, wr_app, rd_hit, rd_miss;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.cache_addr)) begin
        hit     = 1'b1;
        hit_idx = i[PW-1:0];
      end
    end
  end

  // A write hitting the head while it is on the memory bus must not
  // change the line under flight; it becomes an append once the head pops.
  assign pop      = (state_q == WR) && bus.mem_ready;
  assign full     = (count_q == CW'(DEPTH));
  assign can_acc  = !done_q && ((state_q == IDLE) || (state_q == WR));
  assign head_hit = hit && (state_q == WR) && (hit_idx == head_q);
  assign wr_req   = can_acc && bus.cache_write && !bus.cache_read;
  assign wr_hit   = wr_req && hit && !head_hit;
  assign wr_app   = wr_req && (!hit || (head_hit && pop)) && (!full || pop);
  assign rd_hit   = can_acc && bus.cache_read && hit;
  assign rd_miss  = can_acc && bus.cache_read && !hit && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    done_d      = 1'b0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    count_d     = count_q + CW'(wr_app) - CW'(pop);

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
      mem_write_d     = 1'b0;
      state_d         = IDLE;
    end
    if (wr_hit) begin
      data_d[hit_idx] = bus.cache_wdata;
      done_d          = 1'b1;
    end
    // Append after the pop: when full, tail aliases the slot being freed.
    if (wr_app) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = bus.cache_addr;
      data_d[tail_q]  = bus.cache_wdata;
      tail_d          = tail_q + PW'(1);
      done_d          = 1'b1;
    end
    if (rd_hit) begin
      rdata_d = data_q[hit_idx];
      done_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rd_miss) begin
          state_d    = RD;
          mem_read_d = 1'b1;
          mem_addr_d = bus.cache_addr;
        end else if (count_q != '0) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = (wr_hit && (hit_idx == head_q)) ? bus.cache_wdata : data_q[head_q];
        end
      end
      RD: begin
        if (bus.mem_ready) begin
          state_d    = RESP;
          mem_read_d = 1'b0;
          rdata_d    = bus.mem_rdata;
          done_d     = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      done_q      <= done_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.cache_ready = done_q;
  assign bus.cache_rdata = rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign count_o         = count_q;
  assign empty_o         = (count_q == '0);
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: slow-memory responder, directed vector table,
// multi-cycle sequences and a random phase checked against a coherence model.
module tb_dcache_write_buffer;
  localparam int AW = 28;
  localparam int DW = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;
  logic       empty;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_write_buffer_if #(.AW(AW), .DW(DW)) bif ();

  dcache_write_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif.slave),
    .count_o (count),
    .empty_o (empty)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } mlog_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
    int            exp_cnt;
  } vec_t;

  mlog_t         mlog[$];
  logic [DW-1:0] mem_img[logic [AW-1:0]];
  logic [DW-1:0] shadow[logic [AW-1:0]];
  int            n_chk = 0;
  int            n_fail = 0;
  int            mem_lat = 1;
  bit            mem_hold = 1'b0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    mem_fn = {16{8'h5A}} ^ {100'd0, a ^ 28'h40};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slow memory: answers a held request after mem_lat cycles, one-cycle pulse.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    bif.mem_ready = 1'b0;
    bif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bif.mem_ready = 1'b0;
        cnt = 0;
      end else if (bif.mem_ready) begin
        bif.mem_ready = 1'b0;
        cnt = 0;
      end else if ((bif.mem_read || bif.mem_write) && !mem_hold) begin
        cnt++;
        if (cnt >= mem_lat) begin
          bif.mem_ready = 1'b1;
          if (bif.mem_write) begin
            mem_img[bif.mem_addr] = bif.mem_wdata;
            mlog.push_back('{1'b1, bif.mem_addr, bif.mem_wdata, cyc});
          end else begin
            bif.mem_rdata = mem_img.exists(bif.mem_addr) ? mem_img[bif.mem_addr] : mem_fn(bif.mem_addr);
            mlog.push_back('{1'b0, bif.mem_addr, bif.mem_rdata, cyc});
          end
        end
      end
    end
  end

  task automatic cache_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output int rcyc, output int lat, output int cnt);
    int  c0;
    bit  got;
    @(negedge clk);
    bif.cache_read  = !wr;
    bif.cache_write = wr;
    bif.cache_addr  = a;
    bif.cache_wdata = wr ? d : '0;
    c0 = cyc;
    got = 1'b0;
    rd = '0; rcyc = -1; lat = -1; cnt = -1;
    for (int n = 0; n < 400 && !got; n++) begin
      @(posedge clk); #1;
      if (bif.cache_ready) begin
        got  = 1'b1;
        rd   = bif.cache_rdata;
        rcyc = cyc;
        lat  = cyc - c0;
        cnt  = int'(count);
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL cache_op_timeout: no cache_ready for addr %h within 400 cycles", a);
    end
    // Request stays high across one more edge; the pulse must not repeat.
    @(posedge clk); #1;
    chk("ready_width", bif.cache_ready, 0);
    bif.cache_read  = 1'b0;
    bif.cache_write = 1'b0;
    if (wr) shadow[a] = d;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!empty && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", empty, 1);
  endtask

  task automatic chk_log(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (k >= mlog.size()) begin
      n_chk++; n_fail++;
      $display("FAIL log_missing[%0d]: got %0d entries expected more", k, mlog.size());
    end else begin
      chk($sformatf("log_kind[%0d]", k), mlog[k].wr, wr);
      chk($sformatf("log_addr[%0d]", k), mlog[k].a, a);
      if (wr) chk($sformatf("log_data[%0d]", k), mlog[k].d, d);
    end
  endtask

  vec_t          vt[10];
  logic [DW-1:0] rd;
  int            rc, lat, cnt;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vt[0] = '{1'b1, 28'h10, {16{8'hAA}}, '0,           1};
    vt[1] = '{1'b0, 28'h10, '0,          {16{8'hAA}}, 1};
    vt[2] = '{1'b1, 28'h20, {16{8'h11}}, '0,           2};
    vt[3] = '{1'b1, 28'h20, {16{8'h22}}, '0,           2};
    vt[4] = '{1'b0, 28'h20, '0,          {16{8'h22}}, 2};
    vt[5] = '{1'b1, 28'h30, {16{8'h33}}, '0,           3};
    vt[6] = '{1'b1, 28'h40, {16{8'h44}}, '0,           4};
    vt[7] = '{1'b0, 28'h30, '0,          {16{8'h33}}, 4};
    vt[8] = '{1'b1, 28'h20, {16{8'h55}}, '0,           4};
    vt[9] = '{1'b0, 28'h20, '0,          {16{8'h55}}, 4};

    bif.cache_read = 1'b0; bif.cache_write = 1'b0;
    bif.cache_addr = '0;   bif.cache_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", bif.cache_ready, 0);
    chk("rst_rdata", bif.cache_rdata, 0);
    chk("rst_mem_rw", {bif.mem_read, bif.mem_write}, 0);
    chk("rst_mem_addr", bif.mem_addr, 0);
    chk("rst_mem_wdata", bif.mem_wdata, 0);
    @(negedge clk) rst = 1'b0;

    // Reset in the middle of a held memory write.
    mem_hold = 1'b1;
    cache_op(1'b1, 28'h10, {16{8'hC1}}, rd, rc, lat, cnt);
    cache_op(1'b1, 28'h20, {16{8'hC2}}, rd, rc, lat, cnt);
    chk("t1_mem_write", bif.mem_write, 1);
    chk("t1_count", count, 2);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_mem_write", bif.mem_write, 0);
    chk("t1_rst_count", count, 0);
    chk("t1_rst_empty", empty, 1);
    @(negedge clk) rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (bif.cache_ready || bif.mem_write || bif.mem_read) seen = 1'b1;
      end
      chk("t1_quiet_after_rst", seen, 0);
    end
    mem_img.delete(); shadow.delete(); mlog.delete();

    // Read miss behind an in-flight write overtakes the remaining writes.
    mem_lat = 2;
    cache_op(1'b1, 28'h100, {16{8'h01}}, rd, rc, lat, cnt);
    cache_op(1'b1, 28'h110, {16{8'h02}}, rd, rc, lat, cnt);
    cache_op(1'b1, 28'h120, {16{8'h03}}, rd, rc, lat, cnt);
    chk("t5_count", count, 3);
    fork
      cache_op(1'b0, 28'h40, '0, rd, rc, lat, cnt);
      begin
        repeat (4) @(posedge clk);
        mem_hold = 1'b0;
      end
    join
    chk("t5_rdata", rd, {16{8'h5A}});
    if (mlog.size() > 1) chk("t5_ready_after_mem", rc, mlog[1].cyc + 1);
    wait_empty();
    chk("t5_log_size", mlog.size(), 4);
    chk_log(0, 1'b1, 28'h100, {16{8'h01}});
    chk_log(1, 1'b0, 28'h40,  '0);
    chk_log(2, 1'b1, 28'h110, {16{8'h02}});
    chk_log(3, 1'b1, 28'h120, {16{8'h03}});

    // Vector table with memory held: hits, coalescing, fill to full.
    mlog.delete();
    mem_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cache_op(vt[i].wr, vt[i].a, vt[i].d, rd, rc, lat, cnt);
      chk($sformatf("vec%0d_latency", i), lat, 1);
      chk($sformatf("vec%0d_count", i), cnt, vt[i].exp_cnt);
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
    end
    chk("vec_no_mem_done", mlog.size(), 0);
    chk("vec_no_mem_read", bif.mem_read, 0);

    // Full buffer stall, then a write to the in-flight head.
    @(negedge clk);
    mem_lat = 3;
    mem_hold = 1'b0;
    cache_op(1'b1, 28'h50, {16{8'h50}}, rd, rc, lat, cnt);
    chk("t4_count", cnt, 4);
    if (mlog.size() > 0) chk("t4_ready_after_pop", rc, mlog[0].cyc + 1);
    cache_op(1'b1, 28'h20, {16{8'h66}}, rd, rc, lat, cnt);
    chk("t6_count", cnt, 4);
    if (mlog.size() > 1) chk("t6_ready_after_pop", rc, mlog[1].cyc + 1);
    wait_empty();
    chk("t46_log_size", mlog.size(), 6);
    chk_log(0, 1'b1, 28'h10, {16{8'hAA}});
    chk_log(1, 1'b1, 28'h20, {16{8'h55}});
    chk_log(2, 1'b1, 28'h30, {16{8'h33}});
    chk_log(3, 1'b1, 28'h40, {16{8'h44}});
    chk_log(4, 1'b1, 28'h50, {16{8'h50}});
    chk_log(5, 1'b1, 28'h20, {16{8'h66}});

    // Random traffic: every read must see the latest value written to that line.
    for (int i = 0; i < 80; i++) begin
      bit            w;
      logic [AW-1:0] a;
      logic [DW-1:0] d, exp;
      w = 1'($urandom_range(0, 1));
      a = 28'h200 + 28'($urandom_range(0, 5));
      d = {$urandom, $urandom, $urandom, $urandom};
      mem_lat = $urandom_range(1, 4);
      exp = shadow.exists(a) ? shadow[a] : mem_fn(a);
      cache_op(w, a, d, rd, rc, lat, cnt);
      chk($sformatf("rnd%0d_count_bound", i), (cnt >= 0 && cnt <= 4), 1);
      if (!w) chk($sformatf("rnd%0d_rdata", i), rd, exp);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_empty();
    foreach (shadow[k]) begin
      if (!mem_img.exists(k)) begin
        n_chk++; n_fail++;
        $display("FAIL final_mem[%h]: got no write expected %h", k, shadow[k]);
      end else begin
        chk($sformatf("final_mem[%h]", k), mem_img[k], shadow[k]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
